fifo_sync_fwft: RTL and testbench
=================================

// Module: fifo_sync_fwft
// PURPOSE
// - Parametrised synchronous FIFO with first-word-fall-through and a registered output stage.
// - Successor to the bridge's 8-bit/64-deep byte FIFO: any width, any depth >= 2 (non-power-of-2 allowed).
// - valid/ready handshakes on both sides; runtime thresholds; flush; sticky overflow flag.
// - Sits between the UART RX/TX byte paths and the AXI4 frame parser/builder; usable as a generic
//   word buffer elsewhere in the bridge.
// PARAMETERS
// - DATA_WIDTH   8                         payload bits per entry
// - FIFO_DEPTH   64                        total capacity in entries, output register included; >= 2
// - ADDR_WIDTH   $clog2(FIFO_DEPTH)        memory pointer width
// - COUNT_WIDTH  $clog2(FIFO_DEPTH+1)      occupancy width; must represent 0..FIFO_DEPTH
// PORTS
// - clk        in   1            clock; all logic on posedge
// - rst        in   1            synchronous reset, active-high
// - flush      in   1            synchronous clear of contents, same cycle effect as rst on data path
// - wr_valid   in   1            write request
// - wr_data    in   DATA_WIDTH   write payload
// - wr_ready   out  1            = !full; write accepted on edge where wr_valid && wr_ready && !flush
// - rd_valid   out  1            rd_data holds the oldest entry
// - rd_data    out  DATA_WIDTH   registered output data
// - rd_ready   in   1            consumer pops on edge where rd_valid && rd_ready && !flush
// - af_thresh  in   COUNT_WIDTH  almost_full threshold
// - ae_thresh  in   COUNT_WIDTH  almost_empty threshold
// - full       out  1            count == FIFO_DEPTH
// - empty      out  1            count == 0 (equivalently !rd_valid)
// - almost_full  out 1           count >= af_thresh
// - almost_empty out 1           count <= ae_thresh
// - count      out  COUNT_WIDTH  entries held (memory + output register)
// - overflow   out  1            sticky: set on edge with wr_valid && !wr_ready && !flush
// - err_clr    in   1            clears overflow (and hwm when enabled); set wins if same edge
// - hwm        out  COUNT_WIDTH  high-water mark (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: count=0, pointers=0, rd_valid=0, rd_data=0, overflow=0, hwm=0;
//   empty=1, full=0, wr_ready=1. Memory contents are not reset.
// - Flags are combinational from the count register; thresholds are sampled live each cycle.
// - Output stage: when rd_valid=0, or a pop occurs this edge, the stage loads the next entry:
//   - from memory if memory is non-empty;
//   - otherwise bypasses wr_data if a write is accepted this edge (rd_valid=1 next cycle).
//   - Write-to-rd_valid latency when empty: 1 cycle. No bubble under continuous streaming.
// - Memory pointers wrap at FIFO_DEPTH-1 -> 0 explicitly (no power-of-2 reliance).
// - count: +1 on accept-only edge, -1 on pop-only edge, unchanged on both or neither. Never > FIFO_DEPTH.
// - Full with simultaneous pop: wr_ready=0 that cycle (registered-full policy); write is not accepted
//   and sets overflow.
// - Empty: rd_ready is ignored; not an error.
// - flush (or rst): pointers/count/rd_valid -> 0 next edge; a concurrent write or pop is discarded.
//   overflow is not set. Sticky bits survive flush; they are cleared only by rst or err_clr.
// - rd_data holds its value while rd_valid && !rd_ready (stable until popped).
// CONFIGURATION
// - Macro FIFO_HWM_EN:
//   - Defined: hwm register tracks max(count) since rst or err_clr; updates the edge after count rises.
//   - Undefined: hwm tied to 0, no register is inferred.
// - ENABLE_FIFO_ASSERTIONS additionally checks count <= FIFO_DEPTH, !(full && empty),
//   and rd_data stable while stalled.
// TESTING
// - DEPTH=64, W=8: write 0x01..0x40 back-to-back -> full=1 after the 64th edge, count=64,
//   65th write sets overflow=1, count stays 64.
// - Empty FIFO, single write 0xA5 -> rd_valid=1 and rd_data=0xA5 on the next cycle, count=1.
// - Continuous write+read at 1 entry/cycle for 200 cycles -> count constant, data in order, no bubbles.
// - DEPTH=5 (non-power-of-2): 12 writes interleaved with 12 reads -> order preserved across 2 wraps.
// - af_thresh=60, ae_thresh=2: fill to 60 -> almost_full=1 at count 60, 0 at 59;
//   almost_empty=1 at count 2, 0 at 3.
// - count=10, flush asserted with wr_valid=1 and rd_ready=1 -> next cycle count=0, rd_valid=0,
//   overflow unchanged; with FIFO_HWM_EN, hwm=10 until err_clr.

Source files
------------

// File: rtl/fifo_sync_fwft_if.sv
// Handshake bundle for fifo_sync_fwft: write side (producer) and read side (consumer).
interface fifo_sync_fwft_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ready;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered output stage, any depth >= 2.
// Optional high-water mark behind macro FIFO_HWM_EN; checks behind ENABLE_FIFO_ASSERTIONS.
module fifo_sync_fwft #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 64,
  parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
  parameter int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  fifo_sync_fwft_if.slave        bus,
  input  logic [COUNT_WIDTH-1:0] af_thresh,
  input  logic [COUNT_WIDTH-1:0] ae_thresh,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow,
  input  logic                   err_clr,
  output logic [COUNT_WIDTH-1:0] hwm
);

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic                   stage_valid;
  logic [DATA_WIDTH-1:0]  stage_data;
  logic [COUNT_WIDTH-1:0] mem_count;
  logic                   accept;
  logic                   pop;
  logic                   load;
  logic                   mem_read;
  logic                   bypass;
  logic                   mem_write;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
    return (ptr == ADDR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : ptr + ADDR_WIDTH'(1);
  endfunction

  assign full         = (count == COUNT_WIDTH'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);

  assign bus.wr_ready = !full;
  assign bus.rd_valid = stage_valid;
  assign bus.rd_data  = stage_data;

  assign accept    = bus.wr_valid && !full && !flush;
  assign pop       = stage_valid && bus.rd_ready && !flush;
  // Entries parked in memory exclude the one sitting in the output stage.
  assign mem_count = count - COUNT_WIDTH'(stage_valid);
  assign load      = !stage_valid || pop;
  assign mem_read  = load && (mem_count != '0);
  assign bypass    = load && (mem_count == '0) && accept;
  assign mem_write = accept && !bypass;

  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      stage_valid <= 1'b0;
      if (rst) begin
        stage_data <= '0;
      end
    end else begin
      if (mem_write) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (mem_read) begin
        stage_data  <= mem[rd_ptr];
        rd_ptr      <= next_ptr(rd_ptr);
        stage_valid <= 1'b1;
      end else if (bypass) begin
        stage_data  <= bus.wr_data;
        stage_valid <= 1'b1;
      end else if (load) begin
        stage_valid <= 1'b0;
      end
      if (accept && !pop) begin
        count <= count + COUNT_WIDTH'(1);
      end else if (pop && !accept) begin
        count <= count - COUNT_WIDTH'(1);
      end
    end
  end

  // A rejected write takes priority over a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (bus.wr_valid && full && !flush) begin
      overflow <= 1'b1;
    end else if (err_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef FIFO_HWM_EN
  logic [COUNT_WIDTH-1:0] hwm_reg;

  // Clearing restarts tracking from the occupancy present at that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_reg <= '0;
    end else if (err_clr) begin
      hwm_reg <= count;
    end else if (count > hwm_reg) begin
      hwm_reg <= count;
    end
  end

  assign hwm = hwm_reg;
`else
  assign hwm = '0;
`endif

`ifdef ENABLE_FIFO_ASSERTIONS
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= COUNT_WIDTH'(FIFO_DEPTH));
  a_full_empty: assert property (@(posedge clk) disable iff (rst)
    !(full && empty));
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (stage_valid && !bus.rd_ready && !flush) |=> $stable(stage_data));
`endif

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Self-checking bench for fifo_sync_fwft: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model; also a depth-5 instance.
module tb_fifo_sync_fwft;

  localparam int D   = 64;
  localparam int W   = 8;
  localparam int CW  = $clog2(D + 1);
  localparam int D5  = 5;
  localparam int CW5 = $clog2(D5 + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          err_clr;
  logic [CW-1:0] af_thresh;
  logic [CW-1:0] ae_thresh;
  logic          full, empty, almost_full, almost_empty, overflow;
  logic [CW-1:0] count;
  logic [CW-1:0] hwm;

  logic           full5, empty5, af5, ae5, ovf5;
  logic [CW5-1:0] count5;
  logic [CW5-1:0] hwm5;

  int checks   = 0;
  int failures = 0;

  int q[$];
  int q5[$];
  bit ovf_m;
  int hwm_m;

  always #5 clk = ~clk;

  fifo_sync_fwft_if #(.DATA_WIDTH(W)) bus ();
  fifo_sync_fwft_if #(.DATA_WIDTH(W)) bus5 ();

  fifo_sync_fwft #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .err_clr(err_clr), .hwm(hwm)
  );

  fifo_sync_fwft #(.DATA_WIDTH(W), .FIFO_DEPTH(D5)) u_dut5 (
    .clk(clk), .rst(rst), .flush(1'b0), .bus(bus5),
    .af_thresh(CW5'(D5)), .ae_thresh(CW5'(0)),
    .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5),
    .count(count5), .overflow(ovf5), .err_clr(1'b0), .hwm(hwm5)
  );

  typedef struct {
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_ready;
    logic       flush;
    int         exp_count;
    logic       exp_rd_valid;
    logic [7:0] exp_rd_data;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference behaviour at one clock edge, from the inputs present at that edge.
  function automatic void modelEdge();
    int sz;
    bit was_full;
    sz = q.size();
    was_full = (sz == D);
    if (rst) begin
      q.delete();
      ovf_m = 0;
      hwm_m = 0;
      return;
    end
`ifdef FIFO_HWM_EN
    if (err_clr) hwm_m = sz;
    else if (sz > hwm_m) hwm_m = sz;
`endif
    if (bus.wr_valid && was_full && !flush) ovf_m = 1;
    else if (err_clr) ovf_m = 0;
    if (flush) begin
      q.delete();
    end else begin
      if (bus.rd_ready && sz > 0) void'(q.pop_front());
      if (bus.wr_valid && !was_full) q.push_back(int'(bus.wr_data));
    end
  endfunction

  task automatic compareModel();
    int sz;
    sz = q.size();
    checkOutput("count", 32'(count), 32'(sz));
    checkOutput("rd_valid", 32'(bus.rd_valid), 32'(sz > 0));
    if (sz > 0) checkOutput("rd_data", 32'(bus.rd_data), 32'(q[0]));
    checkOutput("full", 32'(full), 32'(sz == D));
    checkOutput("empty", 32'(empty), 32'(sz == 0));
    checkOutput("wr_ready", 32'(bus.wr_ready), 32'(sz != D));
    checkOutput("almost_full", 32'(almost_full), 32'(sz >= int'(af_thresh)));
    checkOutput("almost_empty", 32'(almost_empty), 32'(sz <= int'(ae_thresh)));
    checkOutput("overflow", 32'(overflow), 32'(ovf_m));
    checkOutput("hwm", 32'(hwm), 32'(hwm_m));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    compareModel();
  endtask

  task automatic applyStimulus(input logic r, input logic wv, input logic [7:0] wd,
                               input logic rr, input logic fl, input logic ec);
    rst          = r;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    flush        = fl;
    err_clr      = ec;
    stepCycle();
  endtask

  task automatic step5(input logic wv, input logic [7:0] wd, input logic rr);
    bus5.wr_valid = wv;
    bus5.wr_data  = wd;
    bus5.rd_ready = rr;
    @(posedge clk);
    if (rr && q5.size() > 0) void'(q5.pop_front());
    if (wv && q5.size() < D5) q5.push_back(int'(wd));
    #1;
    checkOutput("d5_count", 32'(count5), 32'(q5.size()));
    checkOutput("d5_rd_valid", 32'(bus5.rd_valid), 32'(q5.size() > 0));
    if (q5.size() > 0) checkOutput("d5_rd_data", 32'(bus5.rd_data), 32'(q5[0]));
    checkOutput("d5_full", 32'(full5), 32'(q5.size() == D5));
    checkOutput("d5_empty", 32'(empty5), 32'(q5.size() == 0));
    checkOutput("d5_af", 32'(af5), 32'(q5.size() >= D5));
    checkOutput("d5_ae", 32'(ae5), 32'(q5.size() == 0));
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 1'b0, 2, 1'b1, 8'h3C};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h11};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 8'h77, 1'b1, 1'b0, 1, 1'b1, 8'h77};
    vecs[7] = '{1'b1, 8'h88, 1'b1, 1'b1, 0, 1'b0, 8'h00};
    vecs[8] = '{1'b1, 8'h99, 1'b0, 1'b0, 1, 1'b1, 8'h99};

    bus5.wr_valid = 1'b0;
    bus5.wr_data  = '0;
    bus5.rd_ready = 1'b0;
    af_thresh = CW'(60);
    ae_thresh = CW'(2);
    ovf_m = 0;
    hwm_m = 0;

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("reset_rd_data", 32'(bus.rd_data), 32'd0);
    checkOutput("reset_hwm", 32'(hwm), 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, vecs[i].wr_valid, vecs[i].wr_data, vecs[i].rd_ready, vecs[i].flush, 1'b0);
      checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_rd_valid));
      if (vecs[i].exp_rd_valid)
        checkOutput($sformatf("vec%0d_rd_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_rd_data));
    end

    // Fill to capacity with thresholds 60/2, then overflow on the 65th write.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= D; k++) begin
      applyStimulus(1'b0, 1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
      if (k == 2) checkOutput("ae_at_2", 32'(almost_empty), 32'd1);
      if (k == 3) checkOutput("ae_at_3", 32'(almost_empty), 32'd0);
      if (k == 59) checkOutput("af_at_59", 32'(almost_full), 32'd0);
      if (k == 60) checkOutput("af_at_60", 32'(almost_full), 32'd1);
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_count", 32'(count), 32'd64);
    checkOutput("fill_ovf_clear", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd64);
    checkOutput("ovf_head", 32'(bus.rd_data), 32'h01);

    // Drain to 10, then flush while writing and popping.
    for (int k = 0; k < 54; k++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_count", 32'(count), 32'd10);
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("flush_ovf_kept", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("errclr_ovf", 32'(overflow), 32'd0);

    // Full with a simultaneous pop: the write is refused and flagged.
    for (int k = 1; k <= D; k++) applyStimulus(1'b0, 1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
    checkOutput("fullpop_count", 32'(count), 32'd63);
    checkOutput("fullpop_ovf", 32'(overflow), 32'd1);
    checkOutput("fullpop_head", 32'(bus.rd_data), 32'h02);

    // Continuous streaming at one entry per cycle.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 8'(8'hC0 + k), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1'b0, 1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
      checkOutput("stream_count", 32'(count), 32'd5);
      checkOutput("stream_valid", 32'(bus.rd_valid), 32'd1);
    end

    // Randomized traffic with alternating fill/drain bias.
    for (int k = 0; k < 3000; k++) begin
      int wp;
      int rp;
      wp = ((k / 200) % 2 == 0) ? 80 : 30;
      rp = ((k / 200) % 2 == 0) ? 30 : 80;
      if (k % 100 == 0) begin
        af_thresh = CW'($urandom_range(0, D));
        ae_thresh = CW'($urandom_range(0, D));
      end
      applyStimulus(1'($urandom_range(0, 499) == 0),
                    1'($urandom_range(0, 99) < wp),
                    8'($urandom),
                    1'($urandom_range(0, 99) < rp),
                    1'($urandom_range(0, 63) == 0),
                    1'($urandom_range(0, 31) == 0));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Depth-5 instance: order preserved across several pointer wraps.
    q5.delete();
    for (int k = 1; k <= 3; k++) step5(1'b1, 8'(k), 1'b0);
    for (int k = 4; k <= 15; k++) step5(1'b1, 8'(k), 1'b1);
    for (int k = 0; k < 4; k++) step5(1'b0, 8'h00, 1'b1);
    checkOutput("d5_ovf", 32'(ovf5), 32'd0);
`ifdef FIFO_HWM_EN
    checkOutput("d5_hwm", 32'(hwm5), 32'd3);
`else
    checkOutput("d5_hwm", 32'(hwm5), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
